// File: rtl/phasecomp_ctrl.sv
// Ping-pong sequencer for the PFB phase-compensation buffer: generates RAM write/read
// addresses, per-frame circular shift offset and a valid/ready handshake on both sides.
module phasecomp_ctrl #(
  parameter int M = 8,
  parameter int D = 6,
  localparam int AW = $clog2(2*M),
  localparam int OW = $clog2(M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          wen,
  output logic [AW-1:0] waddr,
  output logic          ren,
  output logic [AW-1:0] raddr,
  output logic [OW-1:0] shift_offset,
  output logic          primed
);

  // state     | meaning
  // WR_BANK_A | writing bank A [0, M-1], reading bank B
  // WR_BANK_B | writing bank B [M, 2M-1], reading bank A

  if (M < 2 || D < 1 || D >= M) begin : g_bad_param
    $error("phasecomp_ctrl: require M >= 2 and 1 <= D < M");
  end

  typedef enum logic {
    WR_BANK_A = 1'b0,
    WR_BANK_B = 1'b1
  } bank_t;

  bank_t         bank_q, bank_d;
  logic [OW-1:0] wcnt_q, wcnt_d;
  logic [OW-1:0] off_q, off_d;
  logic          primed_q, primed_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;

  logic          acc;
  logic          frame_end;
  logic [AW-1:0] wbase, rbase;
  logic [AW:0]   rd_sum;
  logic [AW-1:0] rd_idx;
  logic [OW:0]   off_sum;
  logic [OW-1:0] off_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q    <= WR_BANK_A;
      wcnt_q    <= '0;
      off_q     <= '0;
      primed_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      wcnt_q    <= wcnt_d;
      off_q     <= off_d;
      primed_q  <= primed_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  always_comb begin
    bank_d    = bank_q;
    wcnt_d    = wcnt_q;
    off_d     = off_q;
    primed_d  = primed_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;

    // RAM dout is the one-deep output register, so a read may only replace it once consumed.
    s_ready   = !rst && (!m_valid_q || m_ready);
    acc       = s_valid && s_ready;
    frame_end = (wcnt_q == OW'(M - 1));

    wbase = (bank_q == WR_BANK_B) ? AW'(M) : '0;
    rbase = (bank_q == WR_BANK_B) ? '0 : AW'(M);

    // (off - 1 - wcnt) mod M without negative intermediates; explicit wrap so M need not be 2^k.
    rd_sum = (AW+1)'(off_q) + (AW+1)'(M - 1) - (AW+1)'(wcnt_q);
    rd_idx = AW'((rd_sum >= (AW+1)'(M)) ? (rd_sum - (AW+1)'(M)) : rd_sum);

    // off - (M-D) is congruent to off + D modulo M.
    off_sum  = (OW+1)'(off_q) + (OW+1)'(D);
    off_next = OW'((off_sum >= (OW+1)'(M)) ? (off_sum - (OW+1)'(M)) : off_sum);

    wen   = acc;
    ren   = acc;
    waddr = wbase + AW'(wcnt_q);
    raddr = rbase + rd_idx;

    if (acc) begin
      m_valid_d = primed_q;
      m_last_d  = primed_q && frame_end;
      if (frame_end) begin
        wcnt_d   = '0;
        bank_d   = (bank_q == WR_BANK_A) ? WR_BANK_B : WR_BANK_A;
        primed_d = 1'b1;
        if (primed_q) begin
          off_d = off_next;
        end
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  assign m_valid      = m_valid_q;
  assign m_last       = m_last_q;
  assign shift_offset = off_q;
  assign primed       = primed_q;

endmodule

// File: tb/tb_phasecomp_ctrl.sv
// Bench for phasecomp_ctrl: two instances (M=8/D=6 and M=5/D=3) each driving a behavioural
// RAM; expected samples are queued at each accept and compared when they appear on dout.
module tb_phasecomp_ctrl;

  localparam int M8 = 8, D8 = 6, AW8 = 4, OW8 = 3;
  localparam int M5 = 5, D5 = 3, AW5 = 4, OW5 = 3;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_m_last;
  logic           a_wen, a_ren, a_primed;
  logic [AW8-1:0] a_waddr, a_raddr;
  logic [OW8-1:0] a_off;
  logic [15:0]    a_din, a_dout;
  logic [15:0]    a_ram [2*M8];

  logic           b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_m_last;
  logic           b_wen, b_ren, b_primed;
  logic [AW5-1:0] b_waddr, b_raddr;
  logic [OW5-1:0] b_off;
  logic [15:0]    b_din, b_dout;
  logic [15:0]    b_ram [2*M5];

  phasecomp_ctrl #(.M(M8), .D(D8)) dut_a (
    .clk(clk), .rst(rst), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_last(a_m_last),
    .wen(a_wen), .waddr(a_waddr), .ren(a_ren), .raddr(a_raddr),
    .shift_offset(a_off), .primed(a_primed)
  );

  phasecomp_ctrl #(.M(M5), .D(D5)) dut_b (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_last(b_m_last),
    .wen(b_wen), .waddr(b_waddr), .ren(b_ren), .raddr(b_raddr),
    .shift_offset(b_off), .primed(b_primed)
  );

  always @(posedge clk) begin
    if (a_wen) a_ram[a_waddr] <= a_din;
    if (a_ren) a_dout <= a_ram[a_raddr];
    if (b_wen) b_ram[b_waddr] <= b_din;
    if (b_ren) b_dout <= b_ram[b_raddr];
  end

  typedef struct {
    int data;
    int last;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];
  int   a_k, b_k;
  int   checks = 0;
  int   errors = 0;
  int   stall_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Offset of read frame f: 0 for f<=1, else -(f-1)*(M-D) mod M == (f-1)*D mod M.
  function automatic int exp_off(input int f, input int m, input int d);
    return (f <= 1) ? 0 : ((f - 1) * d) % m;
  endfunction

  function automatic int exp_idx(input int f, input int n, input int m, input int d);
    return (exp_off(f, m, d) + 2*m - 1 - n) % m;
  endfunction

  task automatic observe_a();
    logic acc;
    int f, n, idx;
    chk("a_s_ready", a_s_ready, (!a_m_valid || a_m_ready));
    acc = a_s_valid && a_s_ready;
    chk("a_wen", a_wen, acc);
    chk("a_ren", a_ren, acc);
    if (a_m_valid) begin
      if (a_q.size() == 0) begin
        chk("a_spurious_valid", a_m_valid, 0);
      end else begin
        chk("a_data", a_dout, a_q[0].data);
        chk("a_last", a_m_last, a_q[0].last);
        if (a_m_ready) void'(a_q.pop_front());
      end
    end
    if (acc) begin
      f   = a_k / M8;
      n   = a_k % M8;
      idx = exp_idx(f, n, M8, D8);
      chk("a_primed", a_primed, (a_k >= M8));
      chk("a_waddr", a_waddr, (f % 2) * M8 + n);
      chk("a_raddr", a_raddr, ((f + 1) % 2) * M8 + idx);
      chk("a_offset", a_off, exp_off(f, M8, D8));
      if (f >= 1) a_q.push_back('{(f - 1) * M8 + idx, (n == M8 - 1)});
      a_k++;
    end
  endtask

  task automatic observe_b();
    logic acc;
    int f, n, idx, rb;
    chk("b_s_ready", b_s_ready, (!b_m_valid || b_m_ready));
    acc = b_s_valid && b_s_ready;
    if (b_m_valid) begin
      if (b_q.size() == 0) begin
        chk("b_spurious_valid", b_m_valid, 0);
      end else begin
        chk("b_data", b_dout, b_q[0].data);
        chk("b_last", b_m_last, b_q[0].last);
        if (b_m_ready) void'(b_q.pop_front());
      end
    end
    if (acc) begin
      f   = b_k / M5;
      n   = b_k % M5;
      idx = exp_idx(f, n, M5, D5);
      rb  = ((f + 1) % 2) * M5;
      chk("b_waddr", b_waddr, (f % 2) * M5 + n);
      chk("b_raddr", b_raddr, rb + idx);
      chk("b_raddr_in_bank", ((int'(b_raddr) >= rb) && (int'(b_raddr) < rb + M5)), 1);
      chk("b_offset", b_off, exp_off(f, M5, D5));
      if (f >= 1) b_q.push_back('{(f - 1) * M5 + idx, (n == M5 - 1)});
      b_k++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_s_valid = 1'b1; a_m_ready = 1'b1;
    b_s_valid = 1'b1; b_m_ready = 1'b1;
    #1;
    chk("a_s_ready_in_rst", a_s_ready, 0);
    chk("a_wen_in_rst", a_wen, 0);
    chk("b_ren_in_rst", b_ren, 0);
    @(negedge clk);
    rst = 1'b0;
    a_s_valid = 1'b0;
    b_s_valid = 1'b0;
    #1;
    chk("a_rst_m_valid", a_m_valid, 0);
    chk("a_rst_m_last", a_m_last, 0);
    chk("a_rst_primed", a_primed, 0);
    chk("a_rst_offset", a_off, 0);
    chk("a_rst_waddr", a_waddr, 0);
    chk("a_rst_raddr", a_raddr, 2*M8 - 1);
    chk("b_rst_raddr", b_raddr, 2*M5 - 1);
    a_q.delete(); b_q.delete();
    a_k = 0; b_k = 0;
    stall_cnt = 0;
  endtask

  task automatic run_a(input int n_acc, input int gap_pct, input int stall_pct);
    int start, cyc;
    start = a_k;
    cyc = 0;
    while ((a_k - start) < n_acc && cyc < BUDGET) begin
      @(negedge clk);
      a_s_valid = ($urandom_range(99) >= gap_pct);
      if (stall_cnt == 0 && $urandom_range(99) < stall_pct) stall_cnt = $urandom_range(5, 1);
      a_m_ready = (stall_cnt == 0);
      if (stall_cnt > 0) stall_cnt--;
      a_din = a_k[15:0];
      #1;
      observe_a();
      cyc++;
    end
    if (cyc >= BUDGET) chk("a_run_timeout", a_k - start, n_acc);
  endtask

  task automatic drain_a();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_s_valid = 1'b0;
      a_m_ready = 1'b1;
      #1;
      observe_a();
    end
    chk("a_sb_empty", a_q.size(), 0);
  endtask

  task automatic run_b(input int n_acc);
    int cyc;
    cyc = 0;
    while (b_k < n_acc && cyc < BUDGET) begin
      @(negedge clk);
      b_s_valid = 1'b1;
      b_m_ready = 1'b1;
      b_din = b_k[15:0];
      #1;
      observe_b();
      cyc++;
    end
    if (cyc >= BUDGET) chk("b_run_timeout", b_k, n_acc);
    @(negedge clk);
    b_s_valid = 1'b0;
    #1;
    observe_b();
    chk("b_sb_empty", b_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    a_s_valid = 1'b0; a_m_ready = 1'b1; a_din = '0;
    b_s_valid = 1'b0; b_m_ready = 1'b1; b_din = '0;
    a_k = 0; b_k = 0;

    do_reset();
    run_a(40, 0, 0);
    drain_a();

    do_reset();
    run_a(40, 0, 25);
    drain_a();

    do_reset();
    run_a(40, 30, 0);
    drain_a();

    // Reset lands on the cycle that would accept wcnt=5 of frame 2.
    do_reset();
    run_a(2*M8 + 5, 0, 0);
    do_reset();
    run_a(40, 0, 0);
    drain_a();

    do_reset();
    run_b(7*M5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
